// File: rtl/src_sync_pkg.sv
// src_sync_pkg: shared definitions for the forwarded-clock serial link.
//   state_t     - transmitter FSM states
//   LINK_WIDTH  - default bits per word (the capture end uses the same value)
//   LINK_DIV    - default sclk half-period in clk cycles
//   cw()        - counter width helper that never returns 0
package src_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int LINK_WIDTH = 8;
  localparam int LINK_DIV   = 2;

  // Width of a counter that must hold 0..n-1; a 1-deep counter still
  // gets one bit so declarations stay legal.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/src_sync_tx_sclk_div.sv
// sclk_div: half-period counter and forwarded-clock toggle flop.
//   clk, rst_n : system clock, async active-low reset
//   en         : count and toggle while high; otherwise sclk parks low
//   start      : force sclk high and restart the half period (word launch)
//   stop       : force sclk low and clear the counter (word end)
//   sclk       : forwarded clock, straight from a flop
//   rise, fall : combinational; high in the cycle before sclk goes 0->1 / 1->0
module sclk_div
  import src_sync_pkg::*;
#(
  parameter int DIV = LINK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic start,
  input  logic stop,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int HCW = cw(DIV);

  logic [HCW-1:0] hc;
  logic           wrap;

  // The toggle happens on the edge that ends the last half-period cycle,
  // so the pulses lead the visible sclk change by one cycle.
  assign wrap = en && (hc == HCW'(DIV - 1));
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc   <= '0;
      sclk <= 1'b0;
    end else if (start) begin
      hc   <= '0;
      sclk <= 1'b1;
    end else if (stop || !en) begin
      hc   <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      hc   <= '0;
      sclk <= ~sclk;
    end else begin
      hc   <= hc + 1'b1;
    end
  end

endmodule

// File: rtl/src_sync_tx.sv
// src_sync_tx: source-synchronous serial transmitter (launch end).
//   clk, rst_n : system clock, async active-low reset
//   in_data    : word to send, captured only on the accept edge
//   in_valid   : in_data valid
//   in_ready   : block can take a word (registered)
//   sclk       : forwarded clock, idle low; data changes on its rising edge
//   sdata      : serial data, MSB first
//   sframe     : high across every bit period of a word
// Each bit spans 2*DIV clk cycles: sclk high for the first DIV, low for the
// last DIV, so the far end samples on the falling edge mid-bit. A word is
// followed by a 2*DIV cycle all-low gap before in_ready returns.
module src_sync_tx
  import src_sync_pkg::*;
#(
  parameter int WIDTH = LINK_WIDTH,
  parameter int DIV   = LINK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             sframe
);

  localparam int BCW = cw(WIDTH);
  localparam int GCW = cw(2 * DIV);

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [BCW-1:0]   bc, bc_n;
  logic [GCW-1:0]   gc, gc_n;
  logic             rdy_n, sdata_n, sframe_n;
  logic             accept, start, stop, en, rise, fall;

  assign accept = in_valid && in_ready;
  assign en     = (state == SHIFT);

  sclk_div #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .stop  (stop),
    .sclk  (sclk),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      bc       <= '0;
      gc       <= '0;
      in_ready <= 1'b0;
      sdata    <= 1'b0;
      sframe   <= 1'b0;
    end else begin
      state    <= state_n;
      sreg     <= sreg_n;
      bc       <= bc_n;
      gc       <= gc_n;
      in_ready <= rdy_n;
      sdata    <= sdata_n;
      sframe   <= sframe_n;
    end
  end

  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    bc_n     = bc;
    gc_n     = gc;
    rdy_n    = in_ready;
    sdata_n  = sdata;
    sframe_n = sframe;
    start    = 1'b0;
    stop     = 1'b0;

    case (state)
      IDLE: begin
        rdy_n = 1'b1;
        bc_n  = '0;
        gc_n  = '0;
        if (accept) begin
          // MSB goes out on the accept edge together with sclk's first rise;
          // the register keeps the remaining bits left-aligned.
          state_n  = SHIFT;
          rdy_n    = 1'b0;
          start    = 1'b1;
          sreg_n   = {in_data[WIDTH-2:0], 1'b0};
          sdata_n  = in_data[WIDTH-1];
          sframe_n = 1'b1;
        end
      end

      SHIFT: begin
        rdy_n = 1'b0;
        // bc counts completed high phases and wraps to 0 after the last
        // bit's fall, so the next would-be rise with bc==0 marks word end.
        if (fall)
          bc_n = (bc == BCW'(WIDTH - 1)) ? '0 : bc + 1'b1;
        if (rise) begin
          if (bc == '0) begin
            state_n  = GAP;
            stop     = 1'b1;
            sdata_n  = 1'b0;
            sframe_n = 1'b0;
            gc_n     = '0;
          end else begin
            sdata_n = sreg[WIDTH-1];
            sreg_n  = {sreg[WIDTH-2:0], 1'b0};
          end
        end
      end

      GAP: begin
        rdy_n = 1'b0;
        if (gc == GCW'(2 * DIV - 1)) begin
          state_n = IDLE;
          rdy_n   = 1'b1;
          gc_n    = '0;
        end else begin
          gc_n = gc + 1'b1;
        end
      end

      default: begin
        state_n  = IDLE;
        rdy_n    = 1'b0;
        sdata_n  = 1'b0;
        sframe_n = 1'b0;
      end
    endcase
  end

endmodule
